// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled serial receiver for start + data + stop frames.
// Data bits arrive LSB first. Each good frame loads dataOut and pulses rxDone.
// A low stop bit pulses frameErr instead.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, the receiver
// expects one even-parity bit before the stop bit and adds the parityErr output.
module uart_receiver #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  baudTick,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  rxDone,
  output logic                  frameErr
`ifdef UART_RX_PARITY_EN
  ,
  output logic                  parityErr
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // START samples half a bit after the detected edge.
  // Every later state samples one full bit period after the previous sample.
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                  state_q, state_d;
  logic                    rx_meta_q, rx_s_q;
  logic [TW-1:0]           tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
  logic                    rx_done_q, rx_done_d;
  logic                    frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic                    par_err_q, par_err_d;
  logic                    parity_err_q, parity_err_d;
`endif

  // Two-flop synchronizer for the asynchronous serial line. It idles high.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State register, counters, shift register and registered output strobes.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_err_q    <= par_err_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Next-state logic: everything advances only on a baud tick.
  // Strobes default low, so each one lasts for a single cycle.
  always_comb begin
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d    = par_err_q;
    parity_err_d = 1'b0;
`endif
    if (baudTick) begin
      case (state_q)
        IDLE: begin
          if (!rx_s_q) begin
            state_d    = START;
            tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
            par_err_d  = 1'b0;
`endif
          end
        end
        START: begin
          if (tick_cnt_q == HALF_LAST) begin
            // If the line is still low at mid start bit, it is a real start bit.
            // Otherwise the low level was a glitch.
            if (!rx_s_q) begin
              state_d    = DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        DATA: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == FULL_LAST) begin
            shift_d   = {rx_s_q, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == FULL_LAST) begin
            // With even parity, the parity bit equals the XOR of all data bits.
            par_err_d = rx_s_q ^ (^shift_q);
            state_d   = STOP;
          end
        end
`endif
        STOP: begin
          tick_cnt_d = tick_cnt_q + 1'b1;
          if (tick_cnt_q == FULL_LAST) begin
            // Return to IDLE at mid stop bit, so a back-to-back frame is caught.
            state_d = IDLE;
            if (!rx_s_q) begin
              frame_err_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_err_q) begin
              parity_err_d = 1'b1;
`endif
            end else begin
              data_out_d = shift_q;
              rx_done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign dataOut   = data_out_q;
  assign rxDone    = rx_done_q;
  assign frameErr  = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parityErr = parity_err_q;
`endif

endmodule
